// File: rtl/sync_beacon_tx.sv
// Beacon pulse transmitter: emits a slotted pulse pattern, one frame of SLOTS slots at a time,
// for a downstream slot-synchronising receiver.
module sync_beacon_tx #(
    parameter int unsigned      SLOT_CYCLES  = 10000,
    parameter int unsigned      PULSE_CYCLES = 1,
    parameter int unsigned      SLOTS        = 3,
    parameter logic [SLOTS-1:0] PATTERN      = 3'b011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rfout,
    output logic        busy,
    output logic [3:0]  slot_idx,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int unsigned     CW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST_CYC    = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]   PULSE_END   = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0]   CYC_ONE     = CW'(1);
    localparam logic [CW-1:0]   CYC_ZERO    = CW'(0);
    localparam logic [3:0]      LAST_SLOT   = 4'(SLOTS - 1);
    // Zero-padded to 16 bits so any 4-bit slot index stays in range.
    localparam logic [15:0]     PATTERN_EXT = 16'(PATTERN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [3:0]     slot_q, slot_d;
    logic           busy_q, busy_d;
    logic           rfout_q, rfout_d;
    logic           frame_done_q, frame_done_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        slot_d       = slot_q;
        busy_d       = busy_q;
        frame_cnt_d  = frame_cnt_q;
        rfout_d      = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cyc_d  = CYC_ZERO;
                slot_d = 4'd0;
                if (en) begin
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_PULSE, ST_HOLD: begin
                // en is only looked at on the frame-end edge, so mid-frame glitches are ignored.
                if (cyc_q == LAST_CYC) begin
                    cyc_d = CYC_ZERO;
                    if (slot_q == LAST_SLOT) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        slot_d      = 4'd0;
                        busy_d      = en;
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            default: begin
                cyc_d  = CYC_ZERO;
                slot_d = 4'd0;
                busy_d = 1'b0;
            end
        endcase

        rfout_d      = busy_d & PATTERN_EXT[slot_d] & (cyc_d < PULSE_END);
        frame_done_d = busy_d & (slot_d == LAST_SLOT) & (cyc_d == LAST_CYC);

        if (!busy_d) begin
            state_d = ST_IDLE;
        end else if (rfout_d) begin
            state_d = ST_PULSE;
        end else begin
            state_d = ST_HOLD;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cyc_q        <= CYC_ZERO;
            slot_q       <= 4'd0;
            busy_q       <= 1'b0;
            rfout_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            slot_q       <= slot_d;
            busy_q       <= busy_d;
            rfout_q      <= rfout_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign rfout      = rfout_q;
    assign busy       = busy_q;
    assign slot_idx   = slot_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sync_beacon_tx.sv
// Directed self-checking bench for sync_beacon_tx: default timing, graceful stop, mid-pulse
// asynchronous reset, pulse width and frame counter wrap.
module tb_sync_beacon_tx;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        rst_a = 1'b0, en_a = 1'b0;
    logic        rfout_a, busy_a, fd_a;
    logic [3:0]  slot_a;
    logic [15:0] cnt_a;

    // Instance B: short slots, 5-cycle pulses, pattern 101
    logic        rst_b = 1'b0, en_b = 1'b0;
    logic        rfout_b, busy_b, fd_b;
    logic [3:0]  slot_b;
    logic [15:0] cnt_b;

    // Instance C: 4-cycle slots, 2 slots, pattern 11
    logic        rst_c = 1'b0, en_c = 1'b0;
    logic        rfout_c, busy_c, fd_c;
    logic [3:0]  slot_c;
    logic [15:0] cnt_c;

    sync_beacon_tx u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .rfout(rfout_a), .busy(busy_a),
        .slot_idx(slot_a), .frame_done(fd_a), .frame_cnt(cnt_a)
    );

    sync_beacon_tx #(
        .SLOT_CYCLES(20), .PULSE_CYCLES(5), .SLOTS(3), .PATTERN(3'b101)
    ) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .rfout(rfout_b), .busy(busy_b),
        .slot_idx(slot_b), .frame_done(fd_b), .frame_cnt(cnt_b)
    );

    sync_beacon_tx #(
        .SLOT_CYCLES(4), .PULSE_CYCLES(1), .SLOTS(2), .PATTERN(2'b11)
    ) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .rfout(rfout_c), .busy(busy_c),
        .slot_idx(slot_c), .frame_done(fd_c), .frame_cnt(cnt_c)
    );

    task automatic test_reset;
        rst_a = 1'b0;
        en_a  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({rfout_a, busy_a, fd_a, slot_a, cnt_a} !== 23'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got rfout=%b busy=%b fd=%b slot=%0d cnt=%0d, want all 0",
                         i, rfout_a, busy_a, fd_a, slot_a, cnt_a);
            end
        end
    endtask

    // Continues from test_reset: release at a negedge with en=1, so the next posedge is T0.
    task automatic test_default_run;
        logic [2:0] pat;
        int mm_rf, mm_busy, mm_slot, mm_fd, mm_cnt, n_fd;
        int pulses[$];
        logic prev;
        bit act;
        int sl;
        pat = 3'b011;
        mm_rf = 0; mm_busy = 0; mm_slot = 0; mm_fd = 0; mm_cnt = 0; n_fd = 0;
        prev = 1'b0;
        rst_a = 1'b1;
        for (int k = 0; k <= 60010; k++) begin
            @(posedge clk);
            @(negedge clk);
            act = (k < 60000);
            sl  = (k / 10000) % 3;
            if (rfout_a !== (act && (k % 10000 == 0) && pat[sl])) mm_rf++;
            if (busy_a !== act) mm_busy++;
            if (slot_a !== (act ? 4'(sl) : 4'd0)) mm_slot++;
            if (fd_a !== (act && (k % 30000 == 29999))) mm_fd++;
            if (cnt_a !== ((k < 30000) ? 16'd0 : (k < 60000) ? 16'd1 : 16'd2)) mm_cnt++;
            if (fd_a === 1'b1) n_fd++;
            if (rfout_a === 1'b1 && prev === 1'b0) pulses.push_back(k);
            prev = rfout_a;
            if (k == 0) begin
                checks++;
                if (rfout_a !== 1'b1 || busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL t0_start: got rfout=%b busy=%b, want 1 1", rfout_a, busy_a);
                end
            end
            if (k == 30000) begin
                checks++;
                if (cnt_a !== 16'd1) begin
                    errors++;
                    $display("FAIL cnt_after_frame1: got %0d, want 1", cnt_a);
                end
            end
            // Short en glitch mid-frame, then a real stop request in frame 2.
            if (k == 15000) en_a = 1'b0;
            if (k == 15002) en_a = 1'b1;
            if (k == 45000) en_a = 1'b0;
        end
        checks++;
        if (mm_rf != 0) begin errors++; $display("FAIL default_rfout: %0d bad cycles, want 0", mm_rf); end
        checks++;
        if (mm_busy != 0) begin errors++; $display("FAIL default_busy: %0d bad cycles, want 0", mm_busy); end
        checks++;
        if (mm_slot != 0) begin errors++; $display("FAIL default_slot: %0d bad cycles, want 0", mm_slot); end
        checks++;
        if (mm_fd != 0) begin errors++; $display("FAIL default_frame_done: %0d bad cycles, want 0", mm_fd); end
        checks++;
        if (mm_cnt != 0) begin errors++; $display("FAIL default_frame_cnt: %0d bad cycles, want 0", mm_cnt); end
        checks++;
        if (n_fd != 2) begin errors++; $display("FAIL frame_done_count: got %0d, want 2", n_fd); end
        checks++;
        if (pulses.size() != 4) begin
            errors++;
            $display("FAIL pulse_count: got %0d, want 4", pulses.size());
        end else if (pulses[0] != 0 || pulses[1] != 10000 || pulses[2] != 30000 || pulses[3] != 40000) begin
            errors++;
            $display("FAIL pulse_cycles: got %0d %0d %0d %0d, want 0 10000 30000 40000",
                     pulses[0], pulses[1], pulses[2], pulses[3]);
        end
    endtask

    task automatic test_async_reset_mid_pulse;
        @(negedge clk);
        rst_b = 1'b1;
        en_b  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy_b !== 1'b0 || rfout_b !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: got busy=%b rfout=%b, want 0 0", i, busy_b, rfout_b);
            end
        end
        en_b = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (rfout_b !== 1'b1) begin
            errors++;
            $display("FAIL pulse_before_reset: got rfout=%b, want 1", rfout_b);
        end
        #1 rst_b = 1'b0;
        #1;
        checks++;
        if ({rfout_b, busy_b, fd_b, slot_b, cnt_b} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset: got rfout=%b busy=%b fd=%b slot=%0d cnt=%0d, want all 0",
                     rfout_b, busy_b, fd_b, slot_b, cnt_b);
        end
    endtask

    // Continues with rst_b low and en_b high: release at a negedge, next posedge is T0.
    task automatic test_pulse_width;
        logic [2:0] pat;
        int mm, n_high;
        bit act;
        bit exp_rf;
        int sl;
        pat = 3'b101;
        mm = 0; n_high = 0;
        @(negedge clk);
        rst_b = 1'b1;
        for (int k = 0; k <= 125; k++) begin
            @(posedge clk);
            @(negedge clk);
            act    = (k < 120);
            sl     = (k / 20) % 3;
            exp_rf = act && (k % 20 < 5) && pat[sl];
            if (rfout_b !== exp_rf) mm++;
            if (busy_b !== act) mm++;
            if (slot_b !== (act ? 4'(sl) : 4'd0)) mm++;
            if (fd_b !== (act && (k % 60 == 59))) mm++;
            if (cnt_b !== ((k < 60) ? 16'd0 : (k < 120) ? 16'd1 : 16'd2)) mm++;
            if (rfout_b === 1'b1) n_high++;
            if (k == 70) en_b = 1'b0;
        end
        checks++;
        if (mm != 0) begin errors++; $display("FAIL pulse_width_sweep: %0d bad samples, want 0", mm); end
        checks++;
        if (n_high != 20) begin errors++; $display("FAIL pulse_high_cycles: got %0d, want 20", n_high); end
        checks++;
        if (cnt_b !== 16'd2) begin errors++; $display("FAIL stop_frame_cnt: got %0d, want 2", cnt_b); end
    endtask

    task automatic test_wrap;
        int mm;
        logic [15:0] exp_cnt;
        mm = 0;
        @(negedge clk);
        rst_c = 1'b1;
        en_c  = 1'b1;
        for (int k = 0; k <= 35; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < 8)       exp_cnt = 16'd0;
            else if (k < 10) exp_cnt = 16'd1;
            else if (k < 16) exp_cnt = 16'hFFFE;
            else if (k < 24) exp_cnt = 16'hFFFF;
            else if (k < 32) exp_cnt = 16'h0000;
            else             exp_cnt = 16'h0001;
            if (rfout_c !== (k % 4 == 0)) mm++;
            if (busy_c !== 1'b1) mm++;
            if (slot_c !== 4'((k / 4) % 2)) mm++;
            if (fd_c !== (k % 8 == 7)) mm++;
            if (cnt_c !== exp_cnt) mm++;
            if (k == 16) begin
                checks++;
                if (cnt_c !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h, want ffff", cnt_c); end
            end
            if (k == 24) begin
                checks++;
                if (cnt_c !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h, want 0000", cnt_c); end
            end
            // Preload the counter near its wrap point across one non-frame-end edge.
            if (k == 9) force u_c.frame_cnt_q = 16'hFFFE;
            if (k == 10) release u_c.frame_cnt_q;
        end
        checks++;
        if (mm != 0) begin errors++; $display("FAIL wrap_sweep: %0d bad samples, want 0", mm); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_async_reset_mid_pulse();
        test_pulse_width();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_beacon_tx.md
SYNC_BEACON_TX -- requirements
Module: sync_beacon_tx

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 10000: clock cycles per beacon slot (1 ms at 10 MHz).
REQ-002 SHALL have parameter PULSE_CYCLES, default 1: rfout high-time per transmitted pulse; legal range 1..SLOT_CYCLES-1.
REQ-003 SHALL have parameter SLOTS, default 3: slots per frame; legal range 2..16.
REQ-004 SHALL have parameter PATTERN, default 3'b011, width SLOTS: bit s=1 means a pulse in slot s, bit s=0 means a silent slot.
REQ-005 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en  input  1  run request, level-sensitive.
REQ-008 SHALL have port rfout  output  1  beacon pulse line to the fsm_sync receiver's rfin input.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port slot_idx  output  4  current slot number, 0..SLOTS-1.
REQ-011 SHALL have port frame_done  output  1  one-cycle strobe on the last cycle of each frame.
REQ-012 SHALL have port frame_cnt  output  16  completed-frame count.

Function
REQ-013 SHALL drive every output from a register; there SHALL be no combinational path from en to any output.
REQ-014 SHALL implement three states: IDLE, PULSE (rfout high) and HOLD (rfout low for the remainder of the slot).
REQ-015 In IDLE, the first rising edge sampling en=1 SHALL load cyc=0, slot_idx=0 and busy=1, and SHALL enter PULSE if PATTERN[0]=1, else HOLD; this cycle is T0.
REQ-016 With en=0, IDLE SHALL hold and keep rfout=0 and busy=0.
REQ-017 Slot s SHALL start at cycle T0+s*SLOT_CYCLES.
REQ-018 When PATTERN[s]=1, rfout SHALL be high for exactly PULSE_CYCLES cycles starting at the slot start, then low for the rest of the slot.
REQ-019 When PATTERN[s]=0, rfout SHALL stay low for the whole slot.
REQ-020 The cycle counter SHALL count 0..SLOT_CYCLES-1, wrap to 0 and increment slot_idx; slot_idx SHALL wrap from SLOTS-1 to 0.
REQ-021 frame_done SHALL be high only in the cycle with slot_idx=SLOTS-1 and cyc=SLOT_CYCLES-1.
REQ-022 frame_cnt SHALL increment by 1 on the edge that ends a frame, and SHALL wrap from 0xFFFF to 0x0000.
REQ-023 At the frame-end edge, en=1 SHALL start the next frame seamlessly at slot 0 with no gap cycle.
REQ-024 At the frame-end edge, en=0 SHALL return the block to IDLE with busy=0, slot_idx=0 and rfout=0.
REQ-025 Deasserting en mid-frame SHALL NOT truncate the frame; the current frame SHALL complete all of its slots.
REQ-026 Reasserting en before the frame end SHALL cancel any pending stop.
REQ-027 Glitches on en during a frame SHALL matter only at the frame-end edge.
REQ-028 The counter width SHALL be ceil(log2(SLOT_CYCLES)); the counter SHALL never exceed SLOT_CYCLES-1.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) force state=IDLE, rfout=0, busy=0, slot_idx=0, frame_done=0, frame_cnt=0 and cyc=0, including mid-pulse.
REQ-030 After rst rises, the block SHALL stay in IDLE until the first edge that samples en=1.

Verification
REQ-031 Reset check: assert rst=0 for 2 cycles with en=1 -> all outputs 0 throughout; then release rst -> T0 is the first edge after release.
REQ-032 Default parameters, en held 1 -> rfout high only in cycles T0, T0+10000, T0+30000 and T0+40000; no pulse at T0+20000; frame_done high at T0+29999; frame_cnt=1 at T0+30000; busy never drops.
REQ-033 Graceful stop: drop en at T0+15000 -> slot-1 pulse and slot 2 still occur; busy=0 and slot_idx=0 from T0+30000; no rfout activity afterwards; frame_cnt=1.
REQ-034 Async reset mid-pulse: PULSE_CYCLES=5, pull rst low at T0+2 (between clock edges) -> rfout=0 before the next edge; frame_cnt=0.
REQ-035 Wrap test: SLOT_CYCLES=4, SLOTS=2, PATTERN=2'b11, en=1 for 65536 frames -> frame_cnt goes 0xFFFF then 0x0000; rfout pulses every 4 cycles.
REQ-036 Loopback test: connect rfout to a fsm_sync rfin with default parameters -> the receiver's state output reaches and holds its synchronized value over 3 frames; the self-checking bench compares the pulse cycle numbers against REQ-017.
